// File: rtl/bus_slave_mux_if.sv
// Master-side and slave-segment signals of the bus sequencer, bundled for the port list.
// The slave modport is the sequencer's view; the master modport drives the stimulus side.
interface bus_slave_mux_if #(
    parameter int DW = 32
);
    logic            cyc_i;
    logic            stb_i;
    logic            we_i;
    logic [31:0]     adr_i;
    logic [3:0]      chipselect;
    logic            fault;
    logic [7:0]      s_cyc_o;
    logic            s_stb_o;
    logic            s_we_o;
    logic [7:0]      s_ack_i;
    logic [8*DW-1:0] s_dat_i;
    logic            ack_o;
    logic            err_o;
    logic [DW-1:0]   dat_o;
    logic [1:0]      err_cause_o;
    logic [31:0]     err_adr_o;

    modport slave (
        input  cyc_i, stb_i, we_i, adr_i, chipselect, fault, s_ack_i, s_dat_i,
        output s_cyc_o, s_stb_o, s_we_o, ack_o, err_o, dat_o, err_cause_o, err_adr_o
    );

    modport master (
        output cyc_i, stb_i, we_i, adr_i, chipselect, fault, s_ack_i, s_dat_i,
        input  s_cyc_o, s_stb_o, s_we_o, ack_o, err_o, dat_o, err_cause_o, err_adr_o
    );
endinterface

// File: rtl/bus_slave_mux.sv
// Bus cycle sequencer: routes a decoded master cycle to one of slaves 1..7, returns data/ack or a one-cycle error.
// Decode error -> err_o next cycle; slave ack sampled in ACTIVE -> ack_o next cycle; master holds cyc/stb until ack/err.
module bus_slave_mux #(
    parameter int TIMEOUT = 256,
    parameter int DW      = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    bus_slave_mux_if.slave bus
);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE, ERR} state_t;

    state_t        state_q, state_d;
    logic [2:0]    sel_q, sel_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    s_cyc_q, s_cyc_d;
    logic          s_stb_q, s_stb_d;
    logic          s_we_q, s_we_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic [DW-1:0] dat_q, dat_d;
    logic [1:0]    cause_q, cause_d;
    logic [31:0]   err_adr_q, err_adr_d;

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        timer_d   = timer_q;
        s_cyc_d   = s_cyc_q;
        s_stb_d   = s_stb_q;
        s_we_d    = s_we_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        dat_d     = dat_q;
        cause_d   = cause_q;
        err_adr_d = err_adr_q;

        case (state_q)
            IDLE: begin
                s_cyc_d = 8'h00;
                s_stb_d = 1'b0;
                s_we_d  = 1'b0;
                if (bus.cyc_i && bus.stb_i) begin
                    if (bus.fault) begin
                        state_d   = ERR;
                        err_d     = 1'b1;
                        cause_d   = 2'b01;
                        err_adr_d = bus.adr_i;
                    end else if (bus.chipselect == 4'd0 || bus.chipselect[3]) begin
                        // Selects outside 1..7 have no slave segment behind them.
                        state_d   = ERR;
                        err_d     = 1'b1;
                        cause_d   = 2'b11;
                        err_adr_d = bus.adr_i;
                    end else begin
                        state_d = ACTIVE;
                        sel_d   = bus.chipselect[2:0];
                        timer_d = '0;
                        s_cyc_d = 8'h01 << bus.chipselect[2:0];
                        s_stb_d = 1'b1;
                        s_we_d  = bus.we_i;
                    end
                end
            end
            ACTIVE: begin
                timer_d = timer_q + TW'(1);
                if (!bus.cyc_i) begin
                    state_d = IDLE;
                    s_cyc_d = 8'h00;
                    s_stb_d = 1'b0;
                    s_we_d  = 1'b0;
                end else if (bus.s_ack_i[sel_q]) begin
                    // Ack is checked before the timer so a last-cycle ack still completes.
                    state_d = DONE;
                    ack_d   = 1'b1;
                    dat_d   = bus.s_dat_i[int'(sel_q)*DW +: DW];
                    s_cyc_d = 8'h00;
                    s_stb_d = 1'b0;
                    s_we_d  = 1'b0;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    state_d   = ERR;
                    err_d     = 1'b1;
                    cause_d   = 2'b10;
                    err_adr_d = bus.adr_i;
                    s_cyc_d   = 8'h00;
                    s_stb_d   = 1'b0;
                    s_we_d    = 1'b0;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            timer_q   <= '0;
            s_cyc_q   <= '0;
            s_stb_q   <= 1'b0;
            s_we_q    <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            dat_q     <= '0;
            cause_q   <= '0;
            err_adr_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            timer_q   <= timer_d;
            s_cyc_q   <= s_cyc_d;
            s_stb_q   <= s_stb_d;
            s_we_q    <= s_we_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            dat_q     <= dat_d;
            cause_q   <= cause_d;
            err_adr_q <= err_adr_d;
        end
    end

    assign bus.s_cyc_o     = s_cyc_q;
    assign bus.s_stb_o     = s_stb_q;
    assign bus.s_we_o      = s_we_q;
    assign bus.ack_o       = ack_q;
    assign bus.err_o       = err_q;
    assign bus.dat_o       = dat_q;
    assign bus.err_cause_o = cause_q;
    assign bus.err_adr_o   = err_adr_q;
endmodule
